// File: rtl/e1_ddr_app_master_if.sv
// rtl/e1_ddr_app_master_if.sv - request/response stream and DDR4 app-side bundle for e1_ddr_app_master
// Statistics signals exist only when E1_DDR_APP_MASTER_STATS_EN is defined.
interface e1_ddr_app_master_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int MW = DW / 8
);
  logic          init_calib_complete;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          busy;
`ifdef E1_DDR_APP_MASTER_STATS_EN
  logic [31:0]   stat_wr_cnt;
  logic [31:0]   stat_rd_cnt;
  logic          stat_err;
`endif

  modport master (
    input  init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask,
           rsp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, rsp_valid, rsp_rdata, app_addr, app_cmd, app_en, app_wdf_data,
           app_wdf_mask, app_wdf_wren, app_wdf_end, busy
`ifdef E1_DDR_APP_MASTER_STATS_EN
    , output stat_wr_cnt, stat_rd_cnt, stat_err
`endif
  );

  modport slave (
    output init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask,
           rsp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  req_ready, rsp_valid, rsp_rdata, app_addr, app_cmd, app_en, app_wdf_data,
           app_wdf_mask, app_wdf_wren, app_wdf_end, busy
`ifdef E1_DDR_APP_MASTER_STATS_EN
    , input stat_wr_cnt, stat_rd_cnt, stat_err
`endif
  );
endinterface

// File: rtl/e1_ddr_app_master.sv
// rtl/e1_ddr_app_master.sv - single-beat request stream to DDR4 app commands, in-order read returns
// Define E1_DDR_APP_MASTER_STATS_EN for command counters and the sticky spurious-read flag.
module e1_ddr_app_master #(
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
  parameter int RSP_DEPTH      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  e1_ddr_app_master_if.master bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WRITE, S_READ} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [APP_ADDR_WIDTH-1:0] r_addr;
  logic [2:0]                r_cmd;
  logic [APP_DATA_WIDTH-1:0] r_wdata;
  logic [APP_MASK_WIDTH-1:0] r_wmask;
  logic                      r_cmd_done;
  logic                      r_dat_done;
  logic                      w_cmd_done_nxt;
  logic                      w_dat_done_nxt;
  logic [CW-1:0]             r_in_flight;
  logic [CW-1:0]             r_count;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [APP_DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

  logic w_calib;
  logic w_credit;
  logic w_req_ready;
  logic w_accept;
  logic w_app_en;
  logic w_wren;
  logic w_cmd_acc;
  logic w_dat_acc;
  logic w_cmd_ok;
  logic w_dat_ok;
  logic w_rd_issue;
  logic w_rd_ret;
  logic w_push;
  logic w_pop;
  logic w_unused;

  assign w_calib  = bus.init_calib_complete;
  // Reads need a guaranteed FIFO slot: app_rd_data cannot be back-pressured.
  assign w_credit = ({1'b0, r_in_flight} + {1'b0, r_count}) < (CW + 1)'(RSP_DEPTH);
  assign w_req_ready = (r_state == S_IDLE) && w_calib && (bus.req_write || w_credit);
  assign w_accept    = bus.req_valid && w_req_ready;

  assign w_app_en   = ((r_state == S_WRITE) && !r_cmd_done) || (r_state == S_READ);
  assign w_wren     = (r_state == S_WRITE) && !r_dat_done;
  assign w_cmd_acc  = w_app_en && bus.app_rdy;
  assign w_dat_acc  = w_wren && bus.app_wdf_rdy;
  assign w_cmd_ok   = r_cmd_done || w_cmd_acc;
  assign w_dat_ok   = r_dat_done || w_dat_acc;
  assign w_rd_issue = (r_state == S_READ) && bus.app_rdy;
  assign w_rd_ret   = bus.app_rd_data_valid && (r_in_flight != '0);
  assign w_push     = w_rd_ret;
  assign w_pop      = (r_count != '0) && bus.rsp_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_done_nxt = r_cmd_done;
    w_dat_done_nxt = r_dat_done;
    case (r_state)
      S_CALIB: if (w_calib) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (!w_calib)      w_state_nxt = S_CALIB;
        else if (w_accept) w_state_nxt = bus.req_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        if (w_cmd_ok && w_dat_ok) begin
          w_state_nxt    = w_calib ? S_IDLE : S_CALIB;
          w_cmd_done_nxt = 1'b0;
          w_dat_done_nxt = 1'b0;
        end else begin
          w_cmd_done_nxt = w_cmd_ok;
          w_dat_done_nxt = w_dat_ok;
        end
      end
      S_READ: if (bus.app_rdy) w_state_nxt = w_calib ? S_IDLE : S_CALIB;
      default: w_state_nxt = S_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CALIB;
      r_cmd_done  <= 1'b0;
      r_dat_done  <= 1'b0;
      r_addr      <= '0;
      r_cmd       <= 3'b001;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_in_flight <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_done <= w_cmd_done_nxt;
      r_dat_done <= w_dat_done_nxt;
      if (w_accept) begin
        r_addr <= {bus.req_addr[APP_ADDR_WIDTH-1:3], 3'b000};
        r_cmd  <= bus.req_write ? 3'b000 : 3'b001;
        if (bus.req_write) begin
          r_wdata <= bus.req_wdata;
          r_wmask <= bus.req_wmask;
        end
      end
      case ({w_rd_issue, w_rd_ret})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.app_rd_data;
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = r_cmd;
  assign bus.app_en       = w_app_en;
  assign bus.app_wdf_data = r_wdata;
  assign bus.app_wdf_mask = r_wmask;
  assign bus.app_wdf_wren = w_wren;
  assign bus.app_wdf_end  = w_wren;
  assign bus.rsp_valid    = (r_count != '0);
  assign bus.rsp_rdata    = r_mem[r_rd_ptr];
  assign bus.busy         = (r_state == S_WRITE) || (r_state == S_READ) || (r_in_flight != '0);

  assign w_unused = &{1'b0, bus.req_addr[2:0], bus.app_rd_data_end};

`ifdef E1_DDR_APP_MASTER_STATS_EN
  logic [31:0] r_stat_wr_cnt;
  logic [31:0] r_stat_rd_cnt;
  logic        r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_wr_cnt <= '0;
      r_stat_rd_cnt <= '0;
      r_stat_err    <= 1'b0;
    end else begin
      if (w_cmd_acc && (r_state == S_WRITE)) r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
      if (w_rd_issue)                        r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
      if (bus.app_rd_data_valid && (r_in_flight == '0)) r_stat_err <= 1'b1;
    end
  end

  assign bus.stat_wr_cnt = r_stat_wr_cnt;
  assign bus.stat_rd_cnt = r_stat_rd_cnt;
  assign bus.stat_err    = r_stat_err;
`endif
endmodule
